mem_port_arbiter: RTL and testbench

- Shares the processor's single-port program/data RAM between two requesters:
  - **CPU**: driven by the control unit's fetch, load, store, add and sub memory cycles.
  - **HOST**: the program loader / debug port.
- Requests are serialised through a small FSM with round-robin priority.
- A host lock lets the loader own memory exclusively while the CPU is held.
- Sits between the datapath memory interface and the RAM macro. The RAM has synchronous read with 1-cycle latency.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states and requester identity.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        CAPTURE = 2'b10,
        ACK     = 2'b11
    } arb_state_e;

    typedef enum logic {
        CPU  = 1'b0,
        HOST = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-port program/data RAM between the CPU and the host loader.
// Requests are serialised IDLE->GRANT->CAPTURE->ACK with round-robin priority and a host lock.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        last_q, last_d;
    logic          wr_q, wr_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          host_ack_q, host_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;
    logic          busy_q, busy_d;

    logic          cpu_elig;
    logic          host_elig;
    owner_e        pick;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        wr_d         = wr_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;

        // The lock only gates the CPU; an access already granted runs to completion.
        cpu_elig  = cpu_req && !host_lock;
        host_elig = host_req;
        pick      = CPU;
        if (cpu_elig && host_elig) begin
            pick = (last_q == CPU) ? HOST : CPU;
        end else if (host_elig) begin
            pick = HOST;
        end

        case (state_q)
            IDLE: begin
                if (cpu_elig || host_elig) begin
                    state_d     = GRANT;
                    owner_d     = pick;
                    mem_en_d    = 1'b1;
                    mem_we_d    = (pick == HOST) ? host_we    : cpu_we;
                    mem_addr_d  = (pick == HOST) ? host_addr  : cpu_addr;
                    mem_wdata_d = (pick == HOST) ? host_wdata : cpu_wdata;
                    wr_d        = (pick == HOST) ? host_we    : cpu_we;
                end
            end
            GRANT: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                // mem_we is already cleared here, so wr_q remembers the access direction.
                if (!wr_q) begin
                    if (owner_q == HOST) host_rdata_d = mem_rdata;
                    else                 cpu_rdata_d  = mem_rdata;
                end
                cpu_ack_d  = (owner_q == CPU);
                host_ack_d = (owner_q == HOST);
                state_d    = ACK;
            end
            ACK: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            owner_q      <= CPU;
            last_q       <= HOST;
            wr_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            wr_q         <= wr_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign host_ack   = host_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run scored
// against a transaction-level arbiter model and a shadow copy of the RAM.
module tb_mem_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          cpu_ack, host_ack, mem_en, mem_we, busy;
    logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram     [0:31];
    logic [DW-1:0] ref_mem [0:31];
    logic          ram_clr = 1'b1;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .Clock(Clock), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 Clock = ~Clock;

    // Synchronous-read RAM macro, one cycle of read latency.
    always @(posedge Clock) begin
        if (ram_clr) begin
            for (int i = 0; i < 32; i++) ram[i] <= '0;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic apply_reset();
        @(negedge Clock);
        Reset = 1'b1; cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Counts negedges from index 'start' until the chosen ack; lat=-1 on timeout.
    task automatic wait_ack(input bit is_host, input int start, output int lat);
        lat = -1;
        for (int n = start; n < 40; n++) begin
            @(negedge Clock);
            if ((is_host ? host_ack : cpu_ack) === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    // Both requests are already driven; drop each one right after its ack.
    task automatic both_round(output int cpu_at, output int host_at);
        cpu_at = -1; host_at = -1;
        for (int n = 0; n < 16; n++) begin
            @(negedge Clock);
            if (cpu_ack === 1'b1 && cpu_at < 0)   cpu_at = n;
            if (host_ack === 1'b1 && host_at < 0) host_at = n;
            @(posedge Clock); #1;
            if (cpu_at >= 0)  cpu_req = 1'b0;
            if (host_at >= 0) host_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        cpu_req = 1'b1; host_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h11; cpu_wdata = 8'hFF;
        repeat (2) @(posedge Clock);
        #1 ram_clr = 1'b0;
        @(negedge Clock);
        checks++;
        if ({mem_en, mem_we, cpu_ack, host_ack, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {mem_en, mem_we, cpu_ack, host_ack, busy});
        end
        checks++;
        if (mem_addr !== 5'h00) begin errors++; $display("FAIL reset_addr got %h want 00", mem_addr); end
        checks++;
        if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", mem_wdata); end
        checks++;
        if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_cpu_rdata got %h want 00", cpu_rdata); end
        checks++;
        if (host_rdata !== 8'h00) begin errors++; $display("FAIL reset_host_rdata got %h want 00", host_rdata); end
        cpu_req = 1'b0; host_req = 1'b0;
        @(negedge Clock); Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_cpu_write_read();
        int lat;
        @(posedge Clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h03; cpu_wdata = 8'hA5;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 5'h03, 8'hA5}) begin
            errors++; $display("FAIL wr_mem_cycle1 got %b %b %h %h want 1 1 03 a5", mem_en, mem_we, mem_addr, mem_wdata);
        end
        wait_ack(1'b0, 2, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL wr_ack_cycle got %0d want 3", lat); end
        ref_mem[3] = 8'hA5;
        @(posedge Clock); #1 cpu_req = 1'b0;
        @(posedge Clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
        wait_ack(1'b0, 0, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL rd_ack_cycle got %0d want 3", lat); end
        checks++;
        if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data got %h want a5", cpu_rdata); end
        @(posedge Clock); #1 cpu_req = 1'b0;
        @(negedge Clock);
        checks++;
        if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_width got %b want 0", cpu_ack); end
    endtask

    task automatic test_simultaneous();
        int c_at, h_at, lat;
        apply_reset();
        @(posedge Clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h07; cpu_wdata = 8'h3C;
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'h07;
        both_round(c_at, h_at);
        ref_mem[7] = 8'h3C;
        checks++;
        if (c_at != 3) begin errors++; $display("FAIL sim1_cpu_ack got %0d want 3", c_at); end
        checks++;
        if (h_at != 7) begin errors++; $display("FAIL sim1_host_ack got %0d want 7", h_at); end
        checks++;
        if (host_rdata !== 8'h3C) begin errors++; $display("FAIL sim1_host_rdata got %h want 3c", host_rdata); end
        // A lone CPU access makes the CPU the most recently served requester.
        @(posedge Clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h07;
        wait_ack(1'b0, 0, lat);
        checks++;
        if (lat != 3 || cpu_rdata !== 8'h3C) begin
            errors++; $display("FAIL solo_cpu got lat %0d data %h want 3 3c", lat, cpu_rdata);
        end
        @(posedge Clock); #1 cpu_req = 1'b0;
        @(posedge Clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'h0B; host_wdata = 8'h77;
        both_round(c_at, h_at);
        ref_mem[11] = 8'h77;
        checks++;
        if (h_at != 3) begin errors++; $display("FAIL sim2_host_ack got %0d want 3", h_at); end
        checks++;
        if (c_at != 7) begin errors++; $display("FAIL sim2_cpu_ack got %0d want 7", c_at); end
        checks++;
        if (cpu_rdata !== ref_mem[3]) begin errors++; $display("FAIL sim2_cpu_rdata got %h want %h", cpu_rdata, ref_mem[3]); end
    endtask

    task automatic test_contention();
        int n_c = 0, n_h = 0, acks = 0, prev_n = -1;
        bit prev_host = 1'b0, is_h, c_done, h_done;
        logic [DW-1:0] got;
        @(posedge Clock); #1;
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = AW'($urandom_range(0, 31)); cpu_wdata = DW'($urandom_range(0, 255));
        host_req = 1'b1; host_we = 1'($urandom_range(0, 1)); host_addr = AW'($urandom_range(0, 31)); host_wdata = DW'($urandom_range(0, 255));
        for (int n = 0; n < 60 && acks < 8; n++) begin
            @(negedge Clock);
            c_done = 1'b0; h_done = 1'b0;
            checks++;
            if (cpu_ack === 1'b1 && host_ack === 1'b1) begin
                errors++; $display("FAIL cont_both_ack got 1 1 want one at a time");
            end else if (cpu_ack === 1'b1 || host_ack === 1'b1) begin
                is_h = (host_ack === 1'b1);
                if (prev_n >= 0) begin
                    checks++;
                    if (is_h == prev_host) begin errors++; $display("FAIL cont_alternate got host=%0d twice want alternate", is_h); end
                    checks++;
                    if (n - prev_n != 4) begin errors++; $display("FAIL cont_spacing got %0d want 4", n - prev_n); end
                end
                if (is_h ? host_we : cpu_we) begin
                    if (is_h) ref_mem[host_addr] = host_wdata; else ref_mem[cpu_addr] = cpu_wdata;
                end else begin
                    got = is_h ? host_rdata : cpu_rdata;
                    checks++;
                    if (got !== (is_h ? ref_mem[host_addr] : ref_mem[cpu_addr])) begin
                        errors++; $display("FAIL cont_rdata got %h want %h", got, is_h ? ref_mem[host_addr] : ref_mem[cpu_addr]);
                    end
                end
                prev_n = n; prev_host = is_h; acks++;
                if (is_h) begin n_h++; h_done = 1'b1; end else begin n_c++; c_done = 1'b1; end
            end
            @(posedge Clock); #1;
            if (c_done) begin
                if (n_c < 4) begin cpu_we = 1'($urandom_range(0, 1)); cpu_addr = AW'($urandom_range(0, 31)); cpu_wdata = DW'($urandom_range(0, 255)); end
                else cpu_req = 1'b0;
            end
            if (h_done) begin
                if (n_h < 4) begin host_we = 1'($urandom_range(0, 1)); host_addr = AW'($urandom_range(0, 31)); host_wdata = DW'($urandom_range(0, 255)); end
                else host_req = 1'b0;
            end
        end
        cpu_req = 1'b0; host_req = 1'b0;
        checks++;
        if (n_c != 4 || n_h != 4) begin errors++; $display("FAIL cont_count got cpu %0d host %0d want 4 4", n_c, n_h); end
    endtask

    task automatic test_host_lock();
        int lat;
        @(posedge Clock); #1;
        host_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clock);
            checks++;
            if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL lock_hold cycle %0d got ack %b busy %b want 0 0", n, cpu_ack, busy);
            end
        end
        @(posedge Clock); #1 host_lock = 1'b0;
        wait_ack(1'b0, 0, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL lock_release_ack got %0d want 3", lat); end
        checks++;
        if (cpu_rdata !== ref_mem[3]) begin errors++; $display("FAIL lock_rdata got %h want %h", cpu_rdata, ref_mem[3]); end
        @(posedge Clock); #1 cpu_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit saw_ack = 1'b0;
        @(posedge Clock); #1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'h0A; host_wdata = 8'h5C;
        wait_ack(1'b1, 0, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL mid_preload_ack got %0d want 3", lat); end
        ref_mem[10] = 8'h5C;
        @(posedge Clock); #1 host_req = 1'b0;
        apply_reset();
        @(posedge Clock); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'h0A;
        repeat (3) @(negedge Clock);
        Reset = 1'b1; host_req = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, host_ack, cpu_rdata, host_rdata, busy} !== '0) begin
            errors++; $display("FAIL mid_outputs got en %b we %b addr %h wd %h ack %b%b rd %h %h busy %b want all 0",
                               mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, host_ack, cpu_rdata, host_rdata, busy);
        end
        @(negedge Clock);
        Reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge Clock);
            if (host_ack === 1'b1) saw_ack = 1'b1;
        end
        checks++;
        if (saw_ack) begin errors++; $display("FAIL mid_no_ack got 1 want 0"); end
        checks++;
        if (host_rdata !== 8'h00) begin errors++; $display("FAIL mid_host_rdata got %h want 00", host_rdata); end
    endtask

    task automatic test_write_isolation();
        int lat;
        logic [DW-1:0] c_rd, h_rd, d;
        @(posedge Clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
        wait_ack(1'b0, 0, lat);
        c_rd = ref_mem[3];
        checks++;
        if (cpu_rdata !== c_rd) begin errors++; $display("FAIL iso_cpu_read got %h want %h", cpu_rdata, c_rd); end
        @(posedge Clock); #1 cpu_req = 1'b0;
        @(posedge Clock); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'h0A;
        wait_ack(1'b1, 0, lat);
        h_rd = ref_mem[10];
        checks++;
        if (host_rdata !== h_rd) begin errors++; $display("FAIL iso_host_read got %h want %h", host_rdata, h_rd); end
        @(posedge Clock); #1 host_req = 1'b0;
        d = DW'($urandom_range(0, 255));
        @(posedge Clock); #1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'h1F; host_wdata = d;
        wait_ack(1'b1, 0, lat);
        ref_mem[31] = d;
        checks++;
        if (lat != 3) begin errors++; $display("FAIL iso_ack_cycle got %0d want 3", lat); end
        checks++;
        if (cpu_rdata !== c_rd) begin errors++; $display("FAIL iso_cpu_rdata got %h want %h", cpu_rdata, c_rd); end
        checks++;
        if (host_rdata !== h_rd) begin errors++; $display("FAIL iso_host_rdata got %h want %h", host_rdata, h_rd); end
        @(posedge Clock); #1 host_req = 1'b0;
        @(negedge Clock);
        checks++;
        if (host_ack !== 1'b0) begin errors++; $display("FAIL iso_ack_width got %b want 0", host_ack); end
    endtask

    // Transaction-level model: when the arbiter is free it picks per the
    // round-robin/lock rules, and that requester completes three cycles later.
    task automatic test_random();
        int free_at = 0, ack_at = -1;
        bit ack_host = 1'b0, ack_rd = 1'b0, last_host = 1'b1;
        bit cpu_done = 1'b0, host_done = 1'b0, ce, he, g_host, g_we, exp_c, exp_h;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] ack_exp = '0, g_wd, got;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge Clock); #1;
            if (cpu_done)  begin cpu_req = 1'b0;  cpu_done = 1'b0;  end
            if (host_done) begin host_req = 1'b0; host_done = 1'b0; end
            if (!cpu_req && cyc < 540 && $urandom_range(0, 3) == 0) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = AW'($urandom_range(0, 31)); cpu_wdata = DW'($urandom_range(0, 255));
            end
            if (!host_req && cyc < 540 && $urandom_range(0, 3) == 0) begin
                host_req = 1'b1; host_we = 1'($urandom_range(0, 1));
                host_addr = AW'($urandom_range(0, 31)); host_wdata = DW'($urandom_range(0, 255));
            end
            if (cyc >= 520)                       host_lock = 1'b0;
            else if ($urandom_range(0, 7) == 0)   host_lock = ~host_lock;
            @(negedge Clock);
            exp_c = (ack_at == cyc) && !ack_host;
            exp_h = (ack_at == cyc) && ack_host;
            checks++;
            if (cpu_ack !== exp_c) begin errors++; $display("FAIL rnd_cpu_ack cyc %0d got %b want %b", cyc, cpu_ack, exp_c); end
            checks++;
            if (host_ack !== exp_h) begin errors++; $display("FAIL rnd_host_ack cyc %0d got %b want %b", cyc, host_ack, exp_h); end
            if (ack_at == cyc) begin
                if (ack_rd) begin
                    got = ack_host ? host_rdata : cpu_rdata;
                    checks++;
                    if (got !== ack_exp) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h want %h", cyc, got, ack_exp); end
                end
                if (ack_host) host_done = 1'b1; else cpu_done = 1'b1;
            end
            if (cyc >= free_at) begin
                ce = cpu_req && !host_lock;
                he = host_req;
                if (ce || he) begin
                    g_host    = (ce && he) ? !last_host : he;
                    last_host = g_host;
                    g_we   = g_host ? host_we    : cpu_we;
                    g_addr = g_host ? host_addr  : cpu_addr;
                    g_wd   = g_host ? host_wdata : cpu_wdata;
                    if (g_we) ref_mem[g_addr] = g_wd;
                    else      ack_exp = ref_mem[g_addr];
                    ack_rd   = !g_we;
                    ack_host = g_host;
                    ack_at   = cyc + 3;
                    free_at  = cyc + 4;
                end
            end
        end
        cpu_req = 1'b0; host_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        test_reset();
        test_cpu_write_read();
        test_simultaneous();
        test_contention();
        test_host_lock();
        test_reset_mid();
        test_write_isolation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
